// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier family.
// BOOTH_UNSIGNED_EN adds one iteration so zero-extended operands are fully consumed.
package booth_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} booth_state_e;

  typedef logic [2:0] booth_op_t;

  localparam booth_op_t OP_ZERO = 3'd0;
  localparam booth_op_t OP_PM   = 3'd1;
  localparam booth_op_t OP_P2M  = 3'd2;
  localparam booth_op_t OP_NM   = 3'd3;
  localparam booth_op_t OP_N2M  = 3'd4;

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned IterExtra = 1;
`else
  localparam int unsigned IterExtra = 0;
`endif

  function automatic int unsigned booth_iters(input int unsigned width);
    return width / 2 + IterExtra;
  endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Start/busy/done handshake bundle for the Booth multiplier.
// BOOTH_UNSIGNED_EN adds the is_signed operand qualifier.
interface booth_radix4_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
`ifdef BOOTH_UNSIGNED_EN
  logic               is_signed;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
`ifdef BOOTH_UNSIGNED_EN
    output is_signed,
`endif
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
`ifdef BOOTH_UNSIGNED_EN
    input  is_signed,
`endif
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: {q[i+1], q[i], q[i-1]} window to partial-product op code.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window_i,
  output booth_op_t  op_o
);

  always_comb begin
    op_o = OP_ZERO;
    unique case (window_i)
      3'b000, 3'b111: op_o = OP_ZERO;
      3'b001, 3'b010: op_o = OP_PM;
      3'b011:         op_o = OP_P2M;
      3'b100:         op_o = OP_N2M;
      3'b101, 3'b110: op_o = OP_NM;
      default:        op_o = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per CALC cycle.
// BOOTH_UNSIGNED_EN: adds is_signed (zero/sign extension) and one extra iteration.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  booth_radix4_multiplier_if.slave bus
);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
  end

  localparam int unsigned Iters = booth_iters(WIDTH);
`ifdef BOOTH_UNSIGNED_EN
  // Unsigned M is a WIDTH+1 bit signed value; one guard bit keeps A + 2M in range.
  localparam int unsigned AW = WIDTH + 3;
  localparam int unsigned QW = WIDTH + 2;
`else
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned QW = WIDTH;
`endif
  localparam int unsigned FW   = AW + QW;
  localparam int unsigned CntW = $clog2(Iters) + 1;

  booth_state_e      state_q;
  logic [AW-1:0]     m_q, a_q;
  logic [QW-1:0]     q_q;
  logic              qm1_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [AW-1:0]     m_ext;
  logic [QW-1:0]     q_ext;
  booth_op_t         op;
  logic [AW-1:0]     op_val, sum;
  logic [FW:0]       shift_in, shift_out;
  logic [FW-1:0]     acc_full;

  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    m_ext = {{(AW-WIDTH){bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    q_ext = {{(QW-WIDTH){bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
`else
    m_ext = {{(AW-WIDTH){bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    q_ext = bus.multiplier;
`endif
  end

  booth_r4_recoder u_recoder (
    .window_i ({q_q[1:0], qm1_q}),
    .op_o     (op)
  );

  always_comb begin
    op_val = '0;
    unique case (op)
      OP_PM:   op_val = m_q;
      OP_P2M:  op_val = m_q << 1;
      OP_NM:   op_val = -m_q;
      OP_N2M:  op_val = -(m_q << 1);
      default: op_val = '0;
    endcase
    sum       = a_q + op_val;
    shift_in  = {sum, q_q, qm1_q};
    shift_out = {{2{shift_in[FW]}}, shift_in[FW:2]};
    acc_full  = {a_q, q_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            m_q     <= m_ext;
            a_q     <= '0;
            q_q     <= q_ext;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          a_q   <= shift_out[FW:QW+1];
          q_q   <= shift_out[QW:1];
          qm1_q <= shift_out[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(Iters - 1)) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          product_q <= acc_full[2*WIDTH-1:0];
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed self-checking bench for booth_radix4_multiplier at WIDTH=8.
module tb_booth_radix4_multiplier;

  localparam int unsigned Width = 8;
`ifdef BOOTH_UNSIGNED_EN
  localparam int Lat = Width / 2 + 2;
`else
  localparam int Lat = Width / 2 + 1;
`endif
  localparam int Period = Lat + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  booth_radix4_multiplier_if #(.WIDTH(Width)) bus ();

  booth_radix4_multiplier #(.WIDTH(Width)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_mul(input logic [7:0] m, input logic [7:0] q, input logic sgn,
                        input logic scramble, input logic [15:0] exp_p, input string tag);
    int lat, busy_n, overlap;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = m;
    bus.multiplier = q;
`ifdef BOOTH_UNSIGNED_EN
    bus.is_signed = sgn;
`endif
    @(posedge clk);
    lat = -1; busy_n = 0; overlap = 0; got = 1'b0;
    for (int k = 0; k <= 3 * Lat && !got; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (scramble) begin
        bus.multiplicand = 8'($urandom);
        bus.multiplier   = 8'($urandom);
      end
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end
    end
    check_eq({tag, "_latency"}, lat, Lat);
    check_eq({tag, "_busy_cycles"}, busy_n, Lat - 1);
    check_eq({tag, "_busy_done_overlap"}, overlap, 0);
    check_eq({tag, "_product"}, bus.product, exp_p);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, bus.done, 0);
    check_eq({tag, "_product_held"}, bus.product, exp_p);
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
`ifdef BOOTH_UNSIGNED_EN
    bus.is_signed = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_product", bus.product, 0);
    rst = 1'b0;

    do_mul(8'd7,   8'hFD, 1'b1, 1'b0, 16'hFFEB, "m7_qm3");
    do_mul(8'h80,  8'h80, 1'b1, 1'b0, 16'h4000, "m128_q128");
    do_mul(8'h80,  8'h7F, 1'b1, 1'b0, 16'hC080, "m128_q127");
    do_mul(8'h00,  8'hFF, 1'b1, 1'b0, 16'h0000, "m0_qm1");

    // Held start: back-to-back issue, one result per Period cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 8'd5;
    bus.multiplier = 8'd6;
    @(posedge clk);
    ndone = 0;
    for (int k = 0; k <= 4 * Period - 1; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check_eq("hold_done_pos", k % Period, Lat);
        check_eq("hold_product", bus.product, 16'h001E);
      end
    end
    bus.start = 1'b0;
    check_eq("hold_done_count", ndone, 4);

    // Reset in the second CALC cycle aborts without a done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 8'd3;
    bus.multiplier = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("abort_prior_product", bus.product, 16'h001E);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_done", bus.done, 0);
    check_eq("abort_product", bus.product, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 2 * Period; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    do_mul(8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001, "after_abort");

    do_mul(8'hF9, 8'd13, 1'b1, 1'b1, 16'hFFA5, "scramble_a");
    do_mul(8'd100, 8'hCE, 1'b1, 1'b1, 16'hEC78, "scramble_b");

`ifdef BOOTH_UNSIGNED_EN
    do_mul(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, "unsigned_ff");
    do_mul(8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001, "signed_ff");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
